// File: rtl/multiword_adder_ctrl.sv
// Adds two n*WORDS-bit operands by time-multiplexing one n-bit BinaryAdder, LS chunk first.
// Latency WORDS cycles Start-to-Done; Start is only accepted in IDLE, requests while busy are dropped.

module BinaryAdder #(
    parameter int n = 4
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         Cin,
    output logic [n-1:0] Sum,
    output logic         Cout
);

    logic [n:0] total;

    assign total = {1'b0, A} + {1'b0, B} + {{n{1'b0}}, Cin};
    assign Sum   = total[n-1:0];
    assign Cout  = total[n];

endmodule

module multiword_adder_ctrl #(
    parameter  int n     = 4,
    parameter  int WORDS = 4,
    localparam int W     = n * WORDS,
    localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         Start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Sum,
    output logic         Cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [n-1:0]   add_a;
    logic [n-1:0]   add_b;
    logic [n-1:0]   add_sum;
    logic           add_cout;

    assign add_a = a_q[int'(k_q)*n +: n];
    assign add_b = b_q[int'(k_q)*n +: n];

    BinaryAdder #(.n(n)) u_adder (
        .A    (add_a),
        .B    (add_b),
        .Cin  (carry_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    k_d     = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d[int'(k_q)*n +: n] = add_sum;
                carry_d                 = add_cout;
                // Last chunk: the ripple carry becomes the visible carry-out.
                if (k_q == KW'(WORDS - 1)) begin
                    cout_d  = add_cout;
                    k_d     = '0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    k_d    = k_q + KW'(1);
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Directed bench for multiword_adder_ctrl: a 4x4-bit instance and a single-chunk instance.
module tb_multiword_adder_ctrl;

    logic        clk;
    logic        nrst;
    logic        start4, start1;
    logic [15:0] a4, b4;
    logic [3:0]  a1, b1;
    logic        cin4, cin1;
    logic        busy4, done4, cout4;
    logic [15:0] sum4;
    logic        busy1, done1, cout1;
    logic [3:0]  sum1;

    int total;
    int bad;

    multiword_adder_ctrl #(.n(4), .WORDS(4)) dut4 (
        .clk(clk), .nrst(nrst), .Start(start4), .A(a4), .B(b4), .Cin(cin4),
        .Busy(busy4), .Done(done4), .Sum(sum4), .Cout(cout4)
    );

    multiword_adder_ctrl #(.n(4), .WORDS(1)) dut1 (
        .clk(clk), .nrst(nrst), .Start(start1), .A(a1), .B(b1), .Cin(cin1),
        .Busy(busy1), .Done(done1), .Sum(sum1), .Cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns just after the accepting edge T0.
    task automatic start_op4(input logic [15:0] a, input logic [15:0] b, input logic c);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        #3;
        total++;
        if ({busy4, done4, cout4, sum4} !== 19'd0) begin
            bad++;
            $display("FAIL reset4 got busy=%b done=%b cout=%b sum=%h want all zero", busy4, done4, cout4, sum4);
        end
        total++;
        if ({busy1, done1, cout1, sum1} !== 7'd0) begin
            bad++;
            $display("FAIL reset1 got busy=%b done=%b cout=%b sum=%h want all zero", busy1, done1, cout1, sum1);
        end
        tick();
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] exp_step [4] = '{16'h0005, 16'h0055, 16'h0555, 16'h5555};
        int busy_cnt;
        int done_at;
        busy_cnt = 0;
        done_at  = -1;
        start_op4(16'h1234, 16'h4321, 1'b0);
        total++;
        if (sum4 !== 16'h0000 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL basic_t0 got sum=%h done=%b want 0000 0", sum4, done4);
        end
        if (busy4) busy_cnt++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (busy4) busy_cnt++;
            if (done4 && done_at < 0) done_at = i;
            if (i <= 4) begin
                total++;
                if (sum4 !== exp_step[i-1]) begin
                    bad++;
                    $display("FAIL basic_step%0d got sum=%h want %h", i, sum4, exp_step[i-1]);
                end
            end
        end
        total++;
        if (done_at !== 4) begin
            bad++;
            $display("FAIL basic_latency got %0d want 4", done_at);
        end
        total++;
        if (busy_cnt !== 4) begin
            bad++;
            $display("FAIL basic_busy_cycles got %0d want 4", busy_cnt);
        end
        total++;
        if (sum4 !== 16'h5555 || cout4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold got sum=%h cout=%b done=%b want 5555 0 0", sum4, cout4, done4);
        end
    endtask

    task automatic test_ripple();
        start_op4(16'hFFFF, 16'h0001, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (sum4 !== 16'h0000) begin
                bad++;
                $display("FAIL ripple_step%0d got sum=%h want 0000", i, sum4);
            end
            total++;
            if (cout4 !== (i == 4)) begin
                bad++;
                $display("FAIL ripple_cout%0d got %b want %b", i, cout4, (i == 4));
            end
        end
        tick();
    endtask

    task automatic test_carry_in();
        logic [15:0] ta [2] = '{16'h7FF8, 16'hFFFF};
        logic [15:0] tb [2] = '{16'h0007, 16'hFFFF};
        logic [15:0] es [2] = '{16'h8000, 16'hFFFF};
        logic        ec [2] = '{1'b0, 1'b1};
        for (int v = 0; v < 2; v++) begin
            start_op4(ta[v], tb[v], 1'b1);
            for (int i = 0; i < 4; i++) tick();
            total++;
            if (done4 !== 1'b1 || sum4 !== es[v] || cout4 !== ec[v]) begin
                bad++;
                $display("FAIL cin_vec%0d got done=%b sum=%h cout=%b want 1 %h %b", v, done4, sum4, cout4, es[v], ec[v]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op4(16'h0003, 16'h0005, 1'b0);
        tick();
        a4 = 16'h1111; b4 = 16'h1111; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        total++;
        if (done4 !== 1'b1 || sum4 !== 16'h0008 || cout4 !== 1'b0) begin
            bad++;
            $display("FAIL drop_busy_start got done=%b sum=%h cout=%b want 1 0008 0", done4, sum4, cout4);
        end
        tick();
        total++;
        if (busy4 !== 1'b0) begin
            bad++;
            $display("FAIL drop_requeue got busy=%b want 0", busy4);
        end
        a4 = 16'h0001; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) tick();
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 16'h0002) begin
            bad++;
            $display("FAIL held_t5 got busy=%b done=%b sum=%h want 0 0 0002", busy4, done4, sum4);
        end
        tick();
        total++;
        if (busy4 !== 1'b1 || sum4 !== 16'h0000) begin
            bad++;
            $display("FAIL held_reaccept_t6 got busy=%b sum=%h want 1 0000", busy4, sum4);
        end
        start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 20) begin
            tick();
            cyc++;
        end
        total++;
        if (done4 !== 1'b1 || sum4 !== 16'h0002) begin
            bad++;
            $display("FAIL held_finish got done=%b sum=%h want 1 0002", done4, sum4);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int done_seen;
        int cyc;
        done_seen = 0;
        start_op4(16'h00FF, 16'h0001, 1'b0);
        tick();
        tick();
        #3;
        nrst = 1'b0;
        #1;
        total++;
        if (sum4 !== 16'h0000 || cout4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL abort_clear got sum=%h cout=%b busy=%b done=%b want 0000 0 0 0", sum4, cout4, busy4, done4);
        end
        tick();
        if (done4) done_seen++;
        #3;
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4 || busy4) done_seen++;
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("FAIL abort_no_done got %0d activity cycles want 0", done_seen);
        end
        start_op4(16'h0002, 16'h0003, 1'b0);
        cyc = 0;
        while (!done4 && cyc < 20) begin
            tick();
            cyc++;
        end
        total++;
        if (done4 !== 1'b1 || sum4 !== 16'h0005 || cout4 !== 1'b0) begin
            bad++;
            $display("FAIL abort_restart got done=%b sum=%h cout=%b want 1 0005 0", done4, sum4, cout4);
        end
        tick();
    endtask

    task automatic test_single_word();
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        total++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            bad++;
            $display("FAIL w1_t0 got busy=%b done=%b want 1 0", busy1, done1);
        end
        tick();
        total++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 4'h1 || cout1 !== 1'b1) begin
            bad++;
            $display("FAIL w1_t1 got done=%b busy=%b sum=%h cout=%b want 1 0 1 1", done1, busy1, sum1, cout1);
        end
        tick();
        total++;
        if (done1 !== 1'b0 || sum1 !== 4'h1) begin
            bad++;
            $display("FAIL w1_t2 got done=%b sum=%h want 0 1", done1, sum1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_carry_in();
        test_back_to_back();
        test_reset_abort();
        test_single_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
